// File: rtl/fp_divider_param_if.sv
// Stream bundle for the FP divider: two operand channels (stb/ack) and one result channel.
interface fp_divider_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0] input_a;
    logic         input_a_stb;
    logic         input_a_ack;
    logic [W-1:0] input_b;
    logic         input_b_stb;
    logic         input_b_ack;
    logic [2:0]   rm;
    logic [W-1:0] output_z;
    logic [4:0]   output_z_flags;
    logic         output_z_stb;
    logic         output_z_ack;

    modport master (
        output input_a, input_a_stb, input_b, input_b_stb, rm, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_flags, output_z_stb
    );

    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb, rm, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_flags, output_z_stb
    );
endinterface

// File: rtl/fp_divider_param.sv
// Parametrised IEEE-754 divider: restoring divide (one quotient bit per cycle), five rounding
// modes, subnormal in/out and the five exception flags {invalid, div_by_zero, overflow, underflow, inexact}.
module fp_divider_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_divider_param_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int SW   = MAN_W + 1;
    localparam int RW   = MAN_W + 2;
    localparam int QW   = MAN_W + 3;
    localparam int CW   = $clog2(QW + 1);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW-1:0] EMIN = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] EMAX = EW'(BIAS);
    localparam logic signed [EW-1:0] QW_S = EW'(QW);

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, NORM, DIVIDE, NORM_OUT, ROUND, PACK, PUT_Z
    } state_t;

    state_t               state_q;
    logic [W-1:0]         a_q, b_q, z_q;
    logic [2:0]           rm_q;
    logic                 a_ack_q, b_ack_q, z_stb_q;
    logic [4:0]           flags_q;
    logic                 sign_q;
    logic signed [EW-1:0] ea_q, eb_q, ze_q;
    logic [SW-1:0]        ma_q, mb_q, mant_q;
    logic [RW-1:0]        rem_q;
    logic [QW-1:0]        quo_q, sig_q;
    logic [CW-1:0]        cnt_q;
    logic                 sticky_q, tiny_q, inexact_q;

    // Operand classification straight from the captured words.
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic a_nan, a_snan, a_inf, a_zero, b_nan, b_snan, b_inf, b_zero;

    assign a_exp  = a_q[W-2:MAN_W];
    assign b_exp  = b_q[W-2:MAN_W];
    assign a_frac = a_q[MAN_W-1:0];
    assign b_frac = b_q[MAN_W-1:0];
    assign a_nan  = (&a_exp) && (|a_frac);
    assign b_nan  = (&b_exp) && (|b_frac);
    assign a_snan = a_nan && !a_frac[MAN_W-1];
    assign b_snan = b_nan && !b_frac[MAN_W-1];
    assign a_inf  = (&a_exp) && !(|a_frac);
    assign b_inf  = (&b_exp) && !(|b_frac);
    assign a_zero = !(|a_exp) && !(|a_frac);
    assign b_zero = !(|b_exp) && !(|b_frac);

    logic         spec_hit;
    logic [W-1:0] spec_z;
    logic [4:0]   spec_flags;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        spec_hit   = 1'b1;
        spec_z     = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_z        = QNAN;
            spec_flags[4] = a_snan || b_snan;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            spec_z        = QNAN;
            spec_flags[4] = 1'b1;
        end else if (a_inf) begin
            spec_z = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf || a_zero) begin
            spec_z = {sign_q, {(W-1){1'b0}}};
        end else if (b_zero) begin
            spec_z        = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags[3] = 1'b1;
        end else begin
            spec_hit = 1'b0;
        end
    end

    function automatic logic [CW-1:0] lzc(input logic [SW-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < SW; i++) begin
            if (v[i]) n = CW'(SW - 1 - i);
        end
        return n;
    endfunction

    logic [CW-1:0]        lza, lzb;
    logic [SW-1:0]        na, nb;
    logic signed [EW-1:0] ze_norm;

    always_comb begin
        lza     = lzc(ma_q);
        lzb     = lzc(mb_q);
        na      = ma_q << lza;
        nb      = mb_q << lzb;
        ze_norm = (ea_q - EW'(lza)) - (eb_q - EW'(lzb));
    end

    logic          quo_bit;
    logic [RW-1:0] rem_sub;

    assign quo_bit = rem_q >= RW'(mb_q);
    assign rem_sub = quo_bit ? rem_q - RW'(mb_q) : rem_q;

    // Quotient lies in (0.5,2): a zero MSB costs one exponent step; below emin it denormalises.
    logic [QW-1:0]        sig_a, sig_b;
    logic signed [EW-1:0] ze_a, ze_b, ze_gap;
    logic [2*QW-1:0]      wide;
    logic                 st_b, tiny_b;
    int                   sh;

    always_comb begin
        sig_a = quo_q;
        ze_a  = ze_q;
        if (!quo_q[QW-1]) begin
            sig_a = {quo_q[QW-2:0], 1'b0};
            ze_a  = ze_q - EW'(1);
        end
        sig_b  = sig_a;
        ze_b   = ze_a;
        st_b   = |rem_q;
        tiny_b = 1'b0;
        ze_gap = EMIN - ze_a;
        sh     = 0;
        wide   = '0;
        if (ze_a < EMIN) begin
            sh     = (ze_gap > QW_S) ? QW : int'(ze_gap);
            wide   = {sig_a, {QW{1'b0}}} >> sh;
            sig_b  = wide[2*QW-1:QW];
            st_b   = st_b | (|wide[QW-1:0]);
            tiny_b = 1'b1;
            ze_b   = EMIN;
        end
    end

    logic [SW-1:0]        rnd_mant;
    logic [SW:0]          rnd_sum;
    logic                 rnd_inc, rnd_any;
    logic signed [EW-1:0] rnd_ze;

    always_comb begin
        rnd_any = sig_q[1] | sig_q[0] | sticky_q;
        case (rm_q)
            RM_RTZ:  rnd_inc = 1'b0;
            RM_RDN:  rnd_inc = sign_q & rnd_any;
            RM_RUP:  rnd_inc = !sign_q & rnd_any;
            RM_RMM:  rnd_inc = sig_q[1];
            default: rnd_inc = sig_q[1] & (sig_q[0] | sticky_q | sig_q[2]);
        endcase
        rnd_sum  = {1'b0, sig_q[QW-1:2]} + (SW+1)'(rnd_inc);
        rnd_mant = rnd_sum[SW-1:0];
        rnd_ze   = ze_q;
        if (rnd_sum[SW]) begin
            rnd_mant = rnd_sum[SW:1];
            rnd_ze   = ze_q + EW'(1);
        end
    end

    logic [W-1:0]     pk_z;
    logic [4:0]       pk_flags;
    logic [EXP_W-1:0] pk_exp;
    logic             to_inf;

    always_comb begin
        to_inf = (rm_q == RM_RNE) || (rm_q == RM_RMM) ||
                 ((rm_q == RM_RUP) && !sign_q) || ((rm_q == RM_RDN) && sign_q);
        pk_exp   = mant_q[SW-1] ? EXP_W'(ze_q + EW'(BIAS)) : '0;
        pk_z     = {sign_q, pk_exp, mant_q[MAN_W-1:0]};
        pk_flags = {3'b000, tiny_q & inexact_q, inexact_q};
        if (ze_q > EMAX) begin
            pk_flags = 5'b00101;
            pk_z     = to_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                              : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end
    end

    // NOTE: sequential state uses <= only, so every register sees pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= GET_A;
            a_q       <= '0;
            b_q       <= '0;
            z_q       <= '0;
            rm_q      <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            z_stb_q   <= 1'b0;
            flags_q   <= '0;
            sign_q    <= 1'b0;
            ea_q      <= '0;
            eb_q      <= '0;
            ze_q      <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            mant_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            sig_q     <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            tiny_q    <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (!a_ack_q) begin
                        a_ack_q <= 1'b1;
                    end else if (bus.input_a_stb) begin
                        a_q     <= bus.input_a;
                        a_ack_q <= 1'b0;
                        state_q <= GET_B;
                    end
                end
                GET_B: begin
                    if (!b_ack_q) begin
                        b_ack_q <= 1'b1;
                    end else if (bus.input_b_stb) begin
                        b_q     <= bus.input_b;
                        rm_q    <= (bus.rm > RM_RMM) ? RM_RNE : bus.rm;
                        b_ack_q <= 1'b0;
                        state_q <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q  <= a_q[W-1] ^ b_q[W-1];
                    ea_q    <= (a_exp == '0) ? EMIN : $signed({2'b00, a_exp}) - EW'(BIAS);
                    eb_q    <= (b_exp == '0) ? EMIN : $signed({2'b00, b_exp}) - EW'(BIAS);
                    ma_q    <= {|a_exp, a_frac};
                    mb_q    <= {|b_exp, b_frac};
                    state_q <= SPECIAL;
                end
                SPECIAL: begin
                    if (spec_hit) begin
                        z_q     <= spec_z;
                        flags_q <= spec_flags;
                        z_stb_q <= 1'b1;
                        state_q <= PUT_Z;
                    end else begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    mb_q    <= nb;
                    rem_q   <= RW'(na);
                    quo_q   <= '0;
                    cnt_q   <= '0;
                    ze_q    <= ze_norm;
                    state_q <= DIVIDE;
                end
                DIVIDE: begin
                    quo_q <= {quo_q[QW-2:0], quo_bit};
                    rem_q <= rem_sub << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(QW - 1)) state_q <= NORM_OUT;
                end
                NORM_OUT: begin
                    sig_q    <= sig_b;
                    ze_q     <= ze_b;
                    sticky_q <= st_b;
                    tiny_q   <= tiny_b;
                    state_q  <= ROUND;
                end
                ROUND: begin
                    mant_q    <= rnd_mant;
                    ze_q      <= rnd_ze;
                    inexact_q <= rnd_any;
                    state_q   <= PACK;
                end
                PACK: begin
                    z_q     <= pk_z;
                    flags_q <= pk_flags;
                    z_stb_q <= 1'b1;
                    state_q <= PUT_Z;
                end
                PUT_Z: begin
                    if (bus.output_z_ack) begin
                        z_stb_q <= 1'b0;
                        state_q <= GET_A;
                    end
                end
                default: state_q <= GET_A;
            endcase
        end
    end

    assign bus.input_a_ack    = a_ack_q;
    assign bus.input_b_ack    = b_ack_q;
    assign bus.output_z       = z_q;
    assign bus.output_z_flags = flags_q;
    assign bus.output_z_stb   = z_stb_q;
endmodule

// File: tb/tb_fp_divider_param.sv
// Directed bench for fp_divider_param: single-precision and half-precision instances on one clock.
module tb_fp_divider_param;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    bit   stable_ok;

    fp_divider_param_if sp_if ();
    fp_divider_param_if #(.EXP_W(5), .MAN_W(10)) hp_if ();

    fp_divider_param u_sp (.clk(clk), .rst_n(rst_n), .bus(sp_if));
    fp_divider_param #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .rst_n(rst_n), .bus(hp_if));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic a_ack(input bit hp);
        return hp ? hp_if.input_a_ack : sp_if.input_a_ack;
    endfunction

    function automatic logic b_ack(input bit hp);
        return hp ? hp_if.input_b_ack : sp_if.input_b_ack;
    endfunction

    function automatic logic z_stb(input bit hp);
        return hp ? hp_if.output_z_stb : sp_if.output_z_stb;
    endfunction

    function automatic logic [31:0] z_val(input bit hp);
        return hp ? {16'h0, hp_if.output_z} : sp_if.output_z;
    endfunction

    function automatic logic [4:0] z_flags(input bit hp);
        return hp ? hp_if.output_z_flags : sp_if.output_z_flags;
    endfunction

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic send_a(input bit hp, input logic [31:0] a);
        int n = 0;
        while (!a_ack(hp) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) check("a_ack_wait", 32'(n), 32'd0);
        if (hp) begin
            hp_if.input_a = a[15:0]; hp_if.input_a_stb = 1'b1;
        end else begin
            sp_if.input_a = a; sp_if.input_a_stb = 1'b1;
        end
        @(posedge clk); #1;
        hp_if.input_a_stb = 1'b0;
        sp_if.input_a_stb = 1'b0;
    endtask

    task automatic send_b(input bit hp, input logic [31:0] b, input logic [2:0] rm);
        int n = 0;
        while (!b_ack(hp) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) check("b_ack_wait", 32'(n), 32'd0);
        if (hp) begin
            hp_if.input_b = b[15:0]; hp_if.rm = rm; hp_if.input_b_stb = 1'b1;
        end else begin
            sp_if.input_b = b; sp_if.rm = rm; sp_if.input_b_stb = 1'b1;
        end
        @(posedge clk); #1;
        hp_if.input_b_stb = 1'b0;
        sp_if.input_b_stb = 1'b0;
    endtask

    task automatic get_z(input bit hp, input int hold, output logic [31:0] z, output logic [4:0] fl, output int lat);
        int n = 0;
        while (!z_stb(hp) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        lat = n;
        z   = z_val(hp);
        fl  = z_flags(hp);
        stable_ok = 1'b1;
        if (n >= 200) begin
            check("z_stb_wait", 32'(n), 32'd0);
        end else begin
            repeat (hold) begin
                @(posedge clk); #1;
                if (!z_stb(hp) || z_val(hp) !== z || z_flags(hp) !== fl) stable_ok = 1'b0;
            end
            if (hp) hp_if.output_z_ack = 1'b1; else sp_if.output_z_ack = 1'b1;
            @(posedge clk); #1;
            hp_if.output_z_ack = 1'b0;
            sp_if.output_z_ack = 1'b0;
        end
    endtask

    task automatic vec(input bit hp, input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, input logic [31:0] ez, input logic [4:0] ef, input int elat);
        logic [31:0] z;
        logic [4:0]  fl;
        int          lat;
        send_a(hp, a);
        send_b(hp, b, rm);
        get_z(hp, 0, z, fl, lat);
        check({tag, "_z"}, z, ez);
        check({tag, "_flags"}, 32'(fl), 32'(ef));
        if (elat > 0) check({tag, "_latency"}, 32'(lat), 32'(elat));
    endtask

    initial begin
        logic [31:0] z;
        logic [4:0]  fl;
        int          lat;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        sp_if.input_a = '0; sp_if.input_a_stb = 1'b0; sp_if.input_b = '0; sp_if.input_b_stb = 1'b0;
        sp_if.rm = '0; sp_if.output_z_ack = 1'b0;
        hp_if.input_a = '0; hp_if.input_a_stb = 1'b0; hp_if.input_b = '0; hp_if.input_b_stb = 1'b0;
        hp_if.rm = '0; hp_if.output_z_ack = 1'b0;

        #2;
        check("reset_z", sp_if.output_z, 32'h0);
        check("reset_flags", 32'(sp_if.output_z_flags), 32'h0);
        check("reset_stb", 32'(sp_if.output_z_stb), 32'h0);
        check("reset_a_ack", 32'(sp_if.input_a_ack), 32'h0);
        check("reset_b_ack", 32'(sp_if.input_b_ack), 32'h0);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("a_ack_before_edge", 32'(sp_if.input_a_ack), 32'h0);
        @(posedge clk); #1;
        check("a_ack_first_edge", 32'(sp_if.input_a_ack), 32'h1);

        vec(0, "div6_2",       32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 32);
        vec(0, "third_rne",    32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'b00001, 32);
        vec(0, "third_rtz",    32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'b00001, 0);
        vec(0, "third_rup",    32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'b00001, 0);
        vec(0, "third_rdn",    32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 5'b00001, 0);
        vec(0, "negthird_rdn", 32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 5'b00001, 0);
        vec(0, "negthird_rup", 32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAA, 5'b00001, 0);
        vec(0, "third_rm7",    32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 5'b00001, 0);
        vec(0, "div_by_zero",  32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'b01000, 2);
        vec(0, "zero_zero",    32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000, 2);
        vec(0, "snan",         32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000, 2);
        vec(0, "one_over_inf", 32'h3F800000, 32'h7F800000, 3'd0, 32'h00000000, 5'b00000, 2);
        vec(0, "ovf_rne",      32'h7F7FFFFF, 32'h3F000000, 3'd0, 32'h7F800000, 5'b00101, 0);
        vec(0, "ovf_rtz",      32'h7F7FFFFF, 32'h3F000000, 3'd1, 32'h7F7FFFFF, 5'b00101, 0);
        vec(0, "sub_exact",    32'h00800000, 32'h40000000, 3'd0, 32'h00400000, 5'b00000, 32);
        vec(0, "sub_tiny",     32'h00000001, 32'h40000000, 3'd0, 32'h00000000, 5'b00011, 32);
        vec(0, "sub_inputs",   32'h00400000, 32'h00800000, 3'd0, 32'h3F000000, 5'b00000, 32);
        vec(1, "half_3_2",     32'h00004200, 32'h00004000, 3'd0, 32'h00003E00, 5'b00000, 19);

        // Consumer stalls for 10 cycles with the result pending.
        send_a(0, 32'h3F800000);
        send_b(0, 32'h40400000, 3'd0);
        get_z(0, 10, z, fl, lat);
        check("stall_stable", 32'(stable_ok), 32'h1);
        check("stall_z", z, 32'h3EAAAAAB);
        check("stall_stb_dropped", 32'(sp_if.output_z_stb), 32'h0);
        @(posedge clk); #1;
        check("a_ack_after_z", 32'(sp_if.input_a_ack), 32'h1);

        // Reset pulse while the divider is iterating.
        send_a(0, 32'h40C00000);
        send_b(0, 32'h40000000, 3'd0);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_z", sp_if.output_z, 32'h0);
        check("midrst_flags", 32'(sp_if.output_z_flags), 32'h0);
        check("midrst_stb", 32'(sp_if.output_z_stb), 32'h0);
        check("midrst_b_ack", 32'(sp_if.input_b_ack), 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        vec(0, "after_reset", 32'h40C00000, 32'h3F800000, 3'd0, 32'h40C00000, 5'b00000, 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
